// File: rtl/gpio_cfg_deser_pkg.sv
// Shared types and constants for the GPIO serial configuration deserializer.
package gpio_cfg_pkg;

  localparam int IO_CTRL_BITS = 13;

  typedef logic [IO_CTRL_BITS-1:0] cfg_t;

  // Bit offsets of the pad control fields inside the configuration word.
  localparam int MGMT_ENA    = 0;
  localparam int OEB         = 1;
  localparam int HOLD_OVR    = 2;
  localparam int INP_DIS     = 3;
  localparam int IB_MODE_SEL = 4;
  localparam int ANALOG_EN   = 5;
  localparam int ANALOG_SEL  = 6;
  localparam int ANALOG_POL  = 7;
  localparam int SLOW_SEL    = 8;
  localparam int VTRIP_SEL   = 9;
  localparam int DM_LSB      = 10;

  localparam cfg_t CFG_RESET_INPUT = 13'h0403;
  localparam cfg_t CFG_RESET_BIDIR = 13'h1803;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_LOAD  = 2'b10
  } state_t;

endpackage

// File: rtl/gpio_cfg_deser_if.sv
// Serial configuration chain link: clock, load/reset strobe, data in and data out.
interface gpio_cfg_deser_if;
  logic serial_clock_in;
  logic serial_resetn_in;
  logic serial_data_in;
  logic serial_data_out;

  modport master (
    output serial_clock_in,
    output serial_resetn_in,
    output serial_data_in,
    input  serial_data_out
  );

  modport slave (
    input  serial_clock_in,
    input  serial_resetn_in,
    input  serial_data_in,
    output serial_data_out
  );
endinterface

// File: rtl/gpio_cfg_deser_sync.sv
// Multi-flop synchronizer plus history flop; emits synced level and one-cycle edge pulses.
module serial_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/gpio_cfg_deser.sv
// Per-pad GPIO configuration chain element: oversampled serial shift register with load into pad config.
// Optional build macro GPIO_CFG_LOAD_COUNT_EN adds an 8-bit count of applied loads.
module gpio_cfg_deser
  import gpio_cfg_pkg::*;
#(
  parameter cfg_t RESET_CFG   = CFG_RESET_INPUT,
  parameter int   SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  gpio_cfg_deser_if.slave     chain,
  output cfg_t                cfg_word,
  output logic                mgmt_ena,
  output logic                oeb,
  output logic                hold_ovr,
  output logic                inp_dis,
  output logic                ib_mode_sel,
  output logic                analog_en,
  output logic                analog_sel,
  output logic                analog_pol,
  output logic                slow_sel,
  output logic                vtrip_sel,
  output logic [2:0]          dm,
  output logic                busy
`ifdef GPIO_CFG_LOAD_COUNT_EN
  ,
  output logic [7:0]          load_count
`endif
);

  logic sc_sync, rise_sc, fall_sc;
  logic sn_sync, rise_sn, fall_sn;
  logic sdi_sync, rise_sd, fall_sd;

  // Equal-depth synchronizers keep data aligned with its clock edge.
  serial_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sc (
    .clk(clk), .resetn(resetn), .din(chain.serial_clock_in),
    .level(sc_sync), .rise(rise_sc), .fall(fall_sc)
  );
  serial_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sn (
    .clk(clk), .resetn(resetn), .din(chain.serial_resetn_in),
    .level(sn_sync), .rise(rise_sn), .fall(fall_sn)
  );
  serial_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sd (
    .clk(clk), .resetn(resetn), .din(chain.serial_data_in),
    .level(sdi_sync), .rise(rise_sd), .fall(fall_sd)
  );

  logic unused_edges;
  assign unused_edges = ^{fall_sc, rise_sn, rise_sd, fall_sd};

  state_t state;
  cfg_t   shift_reg;
  logic   load_ev, clear_ev, shift_ev;

  assign load_ev  = fall_sn && sc_sync && (state != ST_LOAD);
  assign clear_ev = !sn_sync && !sc_sync;
  assign shift_ev = rise_sc && sn_sync && (state != ST_LOAD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      cfg_word  <= RESET_CFG;
    end else begin
      if (load_ev) cfg_word <= shift_reg;

      // Load takes precedence over a coincident shift; the shift register is kept on load.
      if (clear_ev)                 shift_reg <= '0;
      else if (shift_ev && !load_ev) shift_reg <= {shift_reg[IO_CTRL_BITS-2:0], sdi_sync};

      unique case (state)
        ST_IDLE:  if (load_ev)                state <= ST_LOAD;
                  else if (shift_ev)          state <= ST_SHIFT;
        ST_SHIFT: if (load_ev)                state <= ST_LOAD;
                  else if (clear_ev)          state <= ST_IDLE;
        ST_LOAD:  if (sn_sync && !sc_sync)    state <= ST_IDLE;
        default:                              state <= ST_IDLE;
      endcase
    end
  end

`ifdef GPIO_CFG_LOAD_COUNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      load_count <= '0;
    else if (load_ev) load_count <= load_count + 8'd1;
  end
`endif

  assign busy                  = (state != ST_IDLE);
  assign chain.serial_data_out = shift_reg[IO_CTRL_BITS-1];

  assign mgmt_ena    = cfg_word[MGMT_ENA];
  assign oeb         = cfg_word[OEB];
  assign hold_ovr    = cfg_word[HOLD_OVR];
  assign inp_dis     = cfg_word[INP_DIS];
  assign ib_mode_sel = cfg_word[IB_MODE_SEL];
  assign analog_en   = cfg_word[ANALOG_EN];
  assign analog_sel  = cfg_word[ANALOG_SEL];
  assign analog_pol  = cfg_word[ANALOG_POL];
  assign slow_sel    = cfg_word[SLOW_SEL];
  assign vtrip_sel   = cfg_word[VTRIP_SEL];
  assign dm          = cfg_word[DM_LSB +: 3];

endmodule

// File: tb/tb_gpio_cfg_deser.sv
// Two-element chain bench for gpio_cfg_deser; the reference model is a 26-bit chain of shifted bits.
module tb_gpio_cfg_deser;
  import gpio_cfg_pkg::*;

  localparam int PH = 8;

  logic clk;
  logic resetn;

  gpio_cfg_deser_if if0 ();
  gpio_cfg_deser_if if1 ();

  assign if1.serial_clock_in  = if0.serial_clock_in;
  assign if1.serial_resetn_in = if0.serial_resetn_in;
  assign if1.serial_data_in   = if0.serial_data_out;

  cfg_t       cfg_word [2];
  logic [1:0] mgmt_ena, oeb, hold_ovr, inp_dis, ib_mode_sel, analog_en;
  logic [1:0] analog_sel, analog_pol, slow_sel, vtrip_sel, busy;
  logic [2:0] dm [2];
`ifdef GPIO_CFG_LOAD_COUNT_EN
  logic [7:0] load_count [2];
`endif

  gpio_cfg_deser u_near (
    .clk(clk), .resetn(resetn), .chain(if0.slave), .cfg_word(cfg_word[0]),
    .mgmt_ena(mgmt_ena[0]), .oeb(oeb[0]), .hold_ovr(hold_ovr[0]), .inp_dis(inp_dis[0]),
    .ib_mode_sel(ib_mode_sel[0]), .analog_en(analog_en[0]), .analog_sel(analog_sel[0]),
    .analog_pol(analog_pol[0]), .slow_sel(slow_sel[0]), .vtrip_sel(vtrip_sel[0]),
    .dm(dm[0]), .busy(busy[0])
`ifdef GPIO_CFG_LOAD_COUNT_EN
    , .load_count(load_count[0])
`endif
  );

  gpio_cfg_deser u_far (
    .clk(clk), .resetn(resetn), .chain(if1.slave), .cfg_word(cfg_word[1]),
    .mgmt_ena(mgmt_ena[1]), .oeb(oeb[1]), .hold_ovr(hold_ovr[1]), .inp_dis(inp_dis[1]),
    .ib_mode_sel(ib_mode_sel[1]), .analog_en(analog_en[1]), .analog_sel(analog_sel[1]),
    .analog_pol(analog_pol[1]), .slow_sel(slow_sel[1]), .vtrip_sel(vtrip_sel[1]),
    .dm(dm[1]), .busy(busy[1])
`ifdef GPIO_CFG_LOAD_COUNT_EN
    , .load_count(load_count[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Every bit ever shifted into the chain; near element holds [12:0], far element [25:13].
  logic [25:0] chain_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    if0.serial_clock_in  = 1'b0;
    if0.serial_resetn_in = 1'b1;
    if0.serial_data_in   = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(PH);
    chain_model = '0;
  endtask

  task automatic send_bit(input logic b);
    if0.serial_clock_in = 1'b0;
    if0.serial_data_in  = b;
    tick(PH);
    if0.serial_clock_in = 1'b1;
    tick(PH);
    chain_model = {chain_model[24:0], b};
    check("sdo", 32'(if0.serial_data_out), 32'(chain_model[12]));
  endtask

  task automatic send_word(input cfg_t w);
    for (int i = IO_CTRL_BITS - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic load_pulse();
    if0.serial_resetn_in = 1'b0;
    tick(PH);
    if0.serial_resetn_in = 1'b1;
    tick(PH);
    if0.serial_clock_in = 1'b0;
    tick(PH);
  endtask

  task automatic clear_pulse();
    if0.serial_clock_in = 1'b0;
    tick(PH);
    if0.serial_resetn_in = 1'b0;
    tick(PH);
    if0.serial_resetn_in = 1'b1;
    tick(PH);
    chain_model = '0;
  endtask

  typedef struct {
    cfg_t       word;
    logic       oeb;
    logic       mgmt;
    logic [2:0] dm;
    logic       vtrip;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{word: 13'h0A55, oeb: 1'b0, mgmt: 1'b1, dm: 3'b010, vtrip: 1'b1};
    vecs[1] = '{word: 13'h1402, oeb: 1'b1, mgmt: 1'b0, dm: 3'b101, vtrip: 1'b0};
    vecs[2] = '{word: 13'h1FFF, oeb: 1'b1, mgmt: 1'b1, dm: 3'b111, vtrip: 1'b1};
    vecs[3] = '{word: 13'h0000, oeb: 1'b0, mgmt: 1'b0, dm: 3'b000, vtrip: 1'b0};
    vecs[4] = '{word: 13'h0203, oeb: 1'b1, mgmt: 1'b1, dm: 3'b000, vtrip: 1'b1};

    apply_reset();

    // Reset defaults
    check("rst_cfg",     32'(cfg_word[0]), 32'h0403);
    check("rst_cfg_far", 32'(cfg_word[1]), 32'h0403);
    check("rst_oeb",     32'(oeb[0]), 32'd1);
    check("rst_inp_dis", 32'(inp_dis[0]), 32'd0);
    check("rst_dm",      32'(dm[0]), 32'b001);
    check("rst_busy",    32'(busy[0]), 32'd0);
    check("rst_sdo",     32'(if0.serial_data_out), 32'd0);

    // Single word shift and load
    send_word(13'h1803);
    check("shift_busy", 32'(busy[0]), 32'd1);
    check("pre_load_cfg", 32'(cfg_word[0]), 32'h0403);
    load_pulse();
    check("ld_cfg",  32'(cfg_word[0]), 32'h1803);
    check("ld_oeb",  32'(oeb[0]), 32'd1);
    check("ld_dm",   32'(dm[0]), 32'b110);
    check("ld_busy", 32'(busy[0]), 32'd0);

    // Two-element chain
    send_word(13'h0007);
    send_word(13'h1FFF);
    load_pulse();
    check("chain_near", 32'(cfg_word[0]), 32'h1FFF);
    check("chain_far",  32'(cfg_word[1]), 32'h0007);

    // Table of words and their field decodes
    for (int i = 0; i < 5; i++) begin
      send_word(vecs[i].word);
      load_pulse();
      check("tbl_cfg",   32'(cfg_word[0]), 32'(vecs[i].word));
      check("tbl_far",   32'(cfg_word[1]), 32'(chain_model[25:13]));
      check("tbl_oeb",   32'(oeb[0]), 32'(vecs[i].oeb));
      check("tbl_mgmt",  32'(mgmt_ena[0]), 32'(vecs[i].mgmt));
      check("tbl_dm",    32'(dm[0]), 32'(vecs[i].dm));
      check("tbl_vtrip", 32'(vtrip_sel[0]), 32'(vecs[i].vtrip));
    end

    // Clear after 12 ones leaves cfg untouched; next load applies zeros
    apply_reset();
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    clear_pulse();
    check("clr_cfg",  32'(cfg_word[0]), 32'h0403);
    check("clr_busy", 32'(busy[0]), 32'd0);
    check("clr_sdo",  32'(if0.serial_data_out), 32'd0);
    send_bit(1'b0);
    load_pulse();
    check("clr_ld_near", 32'(cfg_word[0]), 32'h0000);
    check("clr_ld_far",  32'(cfg_word[1]), 32'h0000);

    // Reset in the middle of a word
    send_word(13'h1234);
    load_pulse();
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    resetn = 1'b0;
    #1;
    check("mid_rst_cfg",  32'(cfg_word[0]), 32'h0403);
    check("mid_rst_far",  32'(cfg_word[1]), 32'h0403);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_sdo",  32'(if0.serial_data_out), 32'd0);
    if0.serial_clock_in = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(PH);
    chain_model = '0;
    check("post_rst_cfg", 32'(cfg_word[0]), 32'h0403);

    // Randomized bit streams with occasional clears
    for (int it = 0; it < 20; it++) begin
      int n;
      n = $urandom_range(1, 30);
      for (int b = 0; b < n; b++) send_bit(1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        clear_pulse();
        check("rnd_clr_busy", 32'(busy[0]), 32'd0);
        n = $urandom_range(1, 4);
        for (int b = 0; b < n; b++) send_bit(1'($urandom));
      end
      load_pulse();
      check("rnd_near", 32'(cfg_word[0]), 32'(chain_model[12:0]));
      check("rnd_far",  32'(cfg_word[1]), 32'(chain_model[25:13]));
    end

`ifdef GPIO_CFG_LOAD_COUNT_EN
    apply_reset();
    check("cnt_rst", 32'(load_count[0]), 32'd0);
    for (int i = 1; i <= 257; i++) begin
      send_bit(1'($urandom));
      load_pulse();
      if (i == 256) check("cnt_wrap", 32'(load_count[0]), 32'd0);
    end
    check("cnt_257", 32'(load_count[0]), 32'd1);
    check("cnt_cfg", 32'(cfg_word[0]), 32'(chain_model[12:0]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
